// File: rtl/regfile_trace_buffer.sv
// Register-file write snooper: records {cycle, addr, data} for every non-x0 write
// into a FILL or WRAP trace buffer and streams it out oldest-first over valid/ready.
module regfile_trace_buffer #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 16,
    parameter int CYC_W    = 16,
    parameter int POST_CNT = 4,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             stop,
    input  logic             mode,
    input  logic             trig_en,
    input  logic [AW-1:0]    trig_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CYC_W-1:0] out_cycle,
    output logic [AW-1:0]    out_addr,
    output logic [XLEN-1:0]  out_data,
    output logic             busy,
    output logic             done,
    output logic [PW:0]      count,
    output logic             overflow
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DRAIN} state_t;

    localparam logic [PW:0] FULL_CNT  = (PW+1)'(DEPTH);
    localparam logic [PW:0] POST_LAST = (PW+1)'(POST_CNT);

    state_t             r_state, w_next;
    logic [PW-1:0]      r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [PW:0]        r_count, r_post;
    logic [CYC_W-1:0]   r_cycle, w_stamp;
    logic               r_mode, r_overflow, r_out_valid;
    logic [CYC_W-1:0]   r_out_cycle;
    logic [AW-1:0]      r_out_addr;
    logic [XLEN-1:0]    r_out_data;
    logic               w_busy, w_full, w_rec, w_trig, w_xfer;

    logic [CYC_W-1:0]   r_mem_cyc  [DEPTH];
    logic [AW-1:0]      r_mem_addr [DEPTH];
    logic [XLEN-1:0]    r_mem_data [DEPTH];

    assign w_busy    = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_full    = (r_count == FULL_CNT);
    // FILL mode never overwrites; WRAP mode records even when full
    assign w_rec     = w_busy && wr_en && (wr_addr != '0) && !(!r_mode && w_full);
    assign w_trig    = (r_state == S_ARMED) && r_mode && trig_en && w_rec && (wr_addr == trig_addr);
    assign w_xfer    = r_out_valid && out_ready;
    assign w_rd_next = r_rd_ptr + 1'b1;
    // Stamp counts cycles since the arm edge, so the first armed cycle is stamp 1
    assign w_stamp   = r_cycle + 1'b1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ARMED: begin
                if (stop)
                    w_next = S_DRAIN;
                else if (w_trig)
                    w_next = (POST_CNT == 0) ? S_DRAIN : S_POST;
                else if (w_rec && !r_mode && (r_count == FULL_CNT - 1'b1))
                    w_next = S_DRAIN;
            end
            S_POST: begin
                if (stop || (w_rec && ((r_post + 1'b1) == POST_LAST)))
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if ((r_count == '0) || (w_xfer && (r_count == (PW+1)'(1))))
                    w_next = S_IDLE;
            end
            default: w_next = r_state;
        endcase
        if (arm)
            w_next = S_ARMED;
    end

    always_ff @(posedge clk) begin
        if (w_rec && !arm) begin
            r_mem_cyc[r_wr_ptr]  <= w_stamp;
            r_mem_addr[r_wr_ptr] <= wr_addr;
            r_mem_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post      <= '0;
            r_cycle     <= '0;
            r_mode      <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_cycle <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            r_state <= w_next;
            if (arm) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_post      <= '0;
                r_cycle     <= '0;
                r_mode      <= mode;
                r_overflow  <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_busy)
                    r_cycle <= r_cycle + 1'b1;
                if (w_rec) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_full) begin
                        r_rd_ptr   <= w_rd_next;
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                    if (r_state == S_POST)
                        r_post <= r_post + 1'b1;
                end
                // First DRAIN cycle is a bubble that preloads the oldest entry
                if (r_state == S_DRAIN) begin
                    if (r_out_valid) begin
                        if (out_ready) begin
                            r_rd_ptr <= w_rd_next;
                            r_count  <= r_count - 1'b1;
                            if (r_count > (PW+1)'(1)) begin
                                r_out_cycle <= r_mem_cyc[w_rd_next];
                                r_out_addr  <= r_mem_addr[w_rd_next];
                                r_out_data  <= r_mem_data[w_rd_next];
                            end else begin
                                r_out_valid <= 1'b0;
                            end
                        end
                    end else if (r_count != '0) begin
                        r_out_cycle <= r_mem_cyc[r_rd_ptr];
                        r_out_addr  <= r_mem_addr[r_rd_ptr];
                        r_out_data  <= r_mem_data[r_rd_ptr];
                        r_out_valid <= 1'b1;
                    end
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_cycle = r_out_cycle;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign busy      = w_busy;
    assign done      = (r_state == S_DRAIN);
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_regfile_trace_buffer.sv
// Bench for regfile_trace_buffer: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the trace buffer.
module tb_regfile_trace_buffer;

    localparam int XLEN = 32, NUM_REGS = 32, DEPTH = 16, CYC_W = 16, POST_CNT = 4;
    localparam int AW = $clog2(NUM_REGS), PW = $clog2(DEPTH);
    localparam int M_IDLE = 0, M_ARMED = 1, M_POST = 2, M_DRAIN = 3;

    logic             clk, rst_n, arm, stop, mode, trig_en, wr_en, out_ready;
    logic [AW-1:0]    trig_addr, wr_addr;
    logic [XLEN-1:0]  wr_data;
    logic             out_valid, busy, done, overflow;
    logic [CYC_W-1:0] out_cycle;
    logic [AW-1:0]    out_addr;
    logic [XLEN-1:0]  out_data;
    logic [PW:0]      count;

    regfile_trace_buffer #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH), .CYC_W(CYC_W), .POST_CNT(POST_CNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop), .mode(mode),
        .trig_en(trig_en), .trig_addr(trig_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_cycle(out_cycle), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done), .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CYC_W-1:0] c;
        logic [AW-1:0]    a;
        logic [XLEN-1:0]  d;
    } ent_t;

    ent_t q[$];
    int   m_st, m_post, tb_cyc, arm_cyc;
    bit   m_ovf, m_mode, m_outv;
    int   n_checks, n_errors;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_st = M_IDLE; m_post = 0; m_ovf = 0; m_mode = 0; m_outv = 0;
    endtask

    // Advance the reference by one clock edge using the inputs applied for it
    task automatic model_step();
        bit   rec;
        ent_t e;
        tb_cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (arm) begin
            q.delete();
            m_ovf = 0; m_post = 0; m_outv = 0;
            m_mode = mode; arm_cyc = tb_cyc; m_st = M_ARMED;
            return;
        end
        if (m_st == M_ARMED || m_st == M_POST) begin
            rec = wr_en && (wr_addr != 0);
            if (rec) begin
                e.c = CYC_W'(tb_cyc - arm_cyc);
                e.a = wr_addr;
                e.d = wr_data;
                q.push_back(e);
                if (q.size() > DEPTH) begin
                    void'(q.pop_front());
                    m_ovf = 1;
                end
            end
            if (stop)
                m_st = M_DRAIN;
            else if (m_st == M_ARMED && rec && m_mode && trig_en && wr_addr == trig_addr)
                m_st = (POST_CNT == 0) ? M_DRAIN : M_POST;
            else if (m_st == M_ARMED && !m_mode && q.size() == DEPTH)
                m_st = M_DRAIN;
            else if (m_st == M_POST && rec) begin
                m_post++;
                if (m_post == POST_CNT) m_st = M_DRAIN;
            end
        end else if (m_st == M_DRAIN) begin
            if (m_outv) begin
                if (out_ready) begin
                    void'(q.pop_front());
                    m_outv = (q.size() != 0);
                    if (q.size() == 0) m_st = M_IDLE;
                end
            end else if (q.size() == 0) begin
                m_st = M_IDLE;
            end else begin
                m_outv = 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("busy", busy, (m_st == M_ARMED || m_st == M_POST));
        check_eq("done", done, (m_st == M_DRAIN));
        check_eq("count", count, q.size());
        check_eq("overflow", overflow, m_ovf);
        check_eq("out_valid", out_valid, m_outv);
        if (m_outv && q.size() != 0) begin
            check_eq("out_cycle", out_cycle, q[0].c);
            check_eq("out_addr", out_addr, q[0].a);
            check_eq("out_data", out_data, q[0].d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit a, input bit s, input bit we, input int wa,
                         input logic [31:0] wd, input bit rdy);
        arm = a; stop = s; wr_en = we; wr_addr = AW'(wa); wr_data = wd; out_ready = rdy;
        tick();
    endtask

    task automatic drain_all();
        for (int i = 0; i < 3 * DEPTH && m_st != M_IDLE; i++) drive(0, 0, 0, 0, 0, 1);
        check_eq("drain_idle", {busy, done}, 2'b00);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; tb_cyc = 0; arm_cyc = 0;
        rst_n = 0; arm = 0; stop = 0; mode = 0; trig_en = 0; trig_addr = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0; out_ready = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_outs", {out_valid, busy, done, overflow, count}, '0);
        check_eq("rst_fields", {out_cycle, out_addr, out_data}, '0);
        rst_n = 1;

        // FILL: 16 writes, x1..x15 then x1 again
        mode = 0;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) drive(0, 0, 1, (i < 15) ? i + 1 : 1, 32'h100 + i, 0);
        check_eq("fill_state", {busy, done, overflow}, 3'b010);
        check_eq("fill_count", count, 16);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("fill_first", {out_valid, out_cycle, out_addr}, {1'b1, 16'd1, 5'd1});
        drain_all();

        // x0 filter
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 32'hDEAD, 0);
        drive(0, 0, 1, 5, 32'h55, 0);
        drive(0, 1, 0, 0, 0, 0);
        check_eq("x0_count", count, 1);
        drive(0, 0, 0, 0, 0, 0);
        check_eq("x0_entry", {out_addr, out_data}, {5'd5, 32'h55});
        drain_all();

        // WRAP with trigger at x7, four post-trigger captures
        mode = 1; trig_en = 1; trig_addr = 7;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) drive(0, 0, 1, i % 32, 32'h1000 + i, 0);
        check_eq("trig_count", count, 11);
        check_eq("trig_ovf", overflow, 0);
        check_eq("trig_first", out_addr, 1);
        drain_all();

        // WRAP overflow, then backpressure pattern
        trig_en = 0;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) drive(0, 0, 1, i, 32'h2000 + i, 0);
        drive(0, 1, 0, 0, 0, 0);
        check_eq("ovf_count", count, 16);
        check_eq("ovf_flag", overflow, 1);
        drive(0, 0, 0, 0, 0, 0);
        check_eq("ovf_first", out_data, 32'h2005);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        check_eq("bp_count", count, 14);
        drain_all();

        // arm during DRAIN with five entries left
        mode = 0;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) drive(0, 0, 1, i, 32'h300 + i, 0);
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1);
        check_eq("rearm_left", count, 5);
        drive(1, 0, 0, 0, 0, 1);
        check_eq("rearm", {out_valid, busy, count}, {1'b0, 1'b1, 5'd0});

        // async reset during POST
        mode = 1; trig_en = 1; trig_addr = 7;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 7, 32'h77, 0);
        drive(0, 0, 1, 3, 32'h33, 0);
        check_eq("post_busy", busy, 1);
        rst_n = 0;
        #1;
        check_eq("arst_outs", {out_valid, busy, done, overflow, count}, '0);
        check_eq("arst_fields", {out_cycle, out_addr, out_data}, '0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 1);
            if ($urandom_range(0, 49) == 0) trig_en = $urandom_range(0, 1);
            if ($urandom_range(0, 29) == 0) trig_addr = AW'($urandom_range(0, 31));
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 7, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
                  $urandom, $urandom_range(0, 9) < 6);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_trace_buffer.md
Name: regfile_trace_buffer

Overview:
- Synthesizable debug block that snoops the register-file write port of the risky core.
- Records each architectural register write (cycle stamp, address, data) into a parametrised on-chip trace buffer.
- Streams the captured entries out oldest-first over a valid/ready port.
- Generalises per-cycle register dumping into hardware: configurable width/depth, fill-or-wrap capture modes, address trigger with post-trigger window.

Parameters:
- XLEN, 32, data width of a register write.
- NUM_REGS, 32, architectural register count; AW = $clog2(NUM_REGS).
- DEPTH, 16, trace entries; power of two, >= 2; PW = $clog2(DEPTH).
- CYC_W, 16, cycle-stamp width.
- POST_CNT, 4, entries captured after trigger in wrap mode; 0 <= POST_CNT < DEPTH.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- arm  in  1  one-cycle pulse: clear buffer, start capture.
- stop  in  1  force end of capture.
- mode  in  1  0 = FILL (stop when full), 1 = WRAP (circular, trigger-terminated); sampled on arm.
- trig_en  in  1  enable address trigger (WRAP only).
- trig_addr  in  AW  register address that fires trigger.
- wr_en  in  1  register-file write strobe.
- wr_addr  in  AW  write destination.
- wr_data  in  XLEN  write value.
- out_valid  out  1  entry available.
- out_ready  in  1  consumer accepts entry.
- out_cycle  out  CYC_W  cycle stamp of entry.
- out_addr  out  AW  register address of entry.
- out_data  out  XLEN  register value of entry.
- busy  out  1  capture in progress (ARMED or POST).
- done  out  1  capture finished, buffer readable (DRAIN).
- count  out  PW+1  valid entries held, 0..DEPTH.
- overflow  out  1  WRAP mode overwrote at least one entry.

Behaviour:
- Reset, async, with rst_n low: state IDLE; wr_ptr, rd_ptr, count, cycle counter, post counter = 0; out_valid, busy, done, overflow = 0; out_cycle/out_addr/out_data = 0. Buffer contents need not reset.
- States and transitions:
  - IDLE -> ARMED on arm.
  - ARMED -> POST on trigger (WRAP).
  - ARMED -> DRAIN on full (FILL) or stop.
  - POST -> DRAIN after POST_CNT captures, or on stop.
  - DRAIN -> IDLE when the last entry is accepted.
  - arm in any state restarts: count = 0, pointers = 0, overflow = 0, cycle = 0, enter ARMED. Pending output is discarded (out_valid drops the next cycle).
- Cycle counter: 0 on the arm cycle; +1 every clock while ARMED/POST; wraps modulo 2^CYC_W.
- Capture: in ARMED/POST, wr_en && wr_addr != 0 writes {cycle, wr_addr, wr_data} at wr_ptr. Then wr_ptr++ (mod DEPTH) and count++ saturating at DEPTH. Writes to x0 are never recorded.
- FILL full: the write that makes count == DEPTH is stored, then go to DRAIN next cycle. Later writes are ignored.
- WRAP full: a write when count == DEPTH overwrites the oldest entry; rd_ptr advances with wr_ptr and overflow sets (sticky until arm).
- Trigger: in ARMED with mode=1 and trig_en, a recorded write with wr_addr == trig_addr is itself captured and moves the block to POST.
  - POST_CNT == 0 goes directly to DRAIN.
  - Writes in POST count toward POST_CNT only if recorded.
- stop and a capture in the same cycle: the write is captured, then go to DRAIN.
- arm and stop in the same cycle: arm wins.
- DRAIN with count == 0 (stop before any write): done=1, out_valid=0; return to IDLE next cycle.
- Readout:
  - out_valid = (state == DRAIN) && count != 0.
  - Output fields are registered from entry rd_ptr, valid in the same cycle as out_valid (read latency absorbed on DRAIN entry: one bubble cycle after entering DRAIN).
  - A transfer occurs when out_valid && out_ready. Then rd_ptr++, count--, and the next entry is presented the following cycle with no bubble.
  - Output fields are held stable while out_valid && !out_ready.
- Entries are produced in capture order, oldest first. In WRAP after overflow, the oldest is the entry at wr_ptr.
- busy = state in {ARMED, POST}; done = state == DRAIN.
- wr_en is ignored in IDLE and DRAIN.

Test Plan:
- FILL, DEPTH=16: arm, write x1..x15 then x1 = 0x100+i on consecutive cycles (16 writes) -> busy drops, done=1, count=16, overflow=0. Drain with out_ready=1 yields addrs 1..15,1 with strictly increasing cycle stamps 1..16. Then IDLE.
- x0 filter: arm, writes to x0 (data 0xDEAD) and x5 = 0x55, then stop -> count=1; single entry addr=5, data=0x55.
- WRAP + trigger, POST_CNT=4: 20 writes to x1..x20 mod 32 with trig_addr=7 (7th write) -> writes 8..11 captured post, then DRAIN. count=11, overflow=0, first out_addr=1, last out_addr=11.
- WRAP overflow: trig_en=0, 20 writes then stop -> count=16, overflow=1; first entry is write #5, last is write #20.
- Backpressure: in DRAIN toggle out_ready 1,0,0,1 -> fields held while stalled; exactly 2 entries consumed; count decrements by 2.
- Reset/arm mid-operation: assert rst_n=0 during POST -> all outputs 0 immediately, state IDLE. Separately, pulse arm during DRAIN with 5 entries left -> out_valid=0 next cycle, count=0, busy=1.
